// File: rtl/cnn_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_acc_pkg
// Description : Shared types and helpers for the CNN accelerator output path.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_acc_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width that never collapses to zero bits for tiny parameter values.
    function automatic int safe_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_channel_find.sv
`default_nettype none
// ============================================================================
// Module      : next_channel_find
// Description : Lowest set bit of en strictly above from_idx (-1 = search all).
// Revision    : 1.0 - initial release
// ============================================================================
module next_channel_find #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]       en,
    input  logic signed [SEL_W:0] from_idx,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(from_idx))) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_drain_mux.sv
`default_nettype none
// ============================================================================
// Module      : channel_drain_mux
// Description : Drains POY rows from each enabled serializer onto a registered
//               valid/ready beat stream with last/row tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_drain_mux
    import cnn_acc_pkg::*;
#(
    parameter int  CHANNEL_N = 2,
    parameter int  POX       = 3,
    parameter int  POY       = 3,
    parameter int  DATA_W    = DATA_W_DEF,
    localparam int SEL_W     = safe_clog2(CHANNEL_N),
    localparam int ROW_W     = safe_clog2(POY)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CHANNEL_N-1:0]          ch_en,
    input  logic [CHANNEL_N*POX*DATA_W-1:0] ser_data,
    output logic [CHANNEL_N-1:0]          ser_shift,
    output logic [POX*DATA_W-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SEL_W-1:0]              mux_sel,
    output logic [ROW_W-1:0]              out_row,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          start_err
);

    localparam int               C_BEAT_W   = POX * DATA_W;
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(POY - 1);

    state_t                r_state, w_state_nxt;
    logic [CHANNEL_N-1:0]  r_en_q;
    logic [C_BEAT_W-1:0]   r_out_data;
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_mux_sel;
    logic [ROW_W-1:0]      r_out_row;
    logic                  r_out_last;
    logic                  r_done;
    logic                  r_start_err;

    logic [C_BEAT_W-1:0]   w_rows [CHANNEL_N];
    logic                  w_first_found, w_next_found;
    logic [SEL_W-1:0]      w_first_idx, w_next_idx;
    logic [SEL_W-1:0]      w_hi_new, w_hi_q, w_ld_hi;
    logic                  w_hs, w_final_hs, w_accept;
    logic                  w_load, w_ld_last;
    logic [SEL_W-1:0]      w_ld_ch;
    logic [ROW_W-1:0]      w_ld_row;
    logic [CHANNEL_N-1:0]  w_shift;

    generate
        for (genvar c = 0; c < CHANNEL_N; c++) begin : g_row_split
            assign w_rows[c] = ser_data[c*C_BEAT_W +: C_BEAT_W];
        end
    endgenerate

    next_channel_find #(.N(CHANNEL_N), .SEL_W(SEL_W)) u_first_find (
        .en       (ch_en),
        .from_idx ({(SEL_W+1){1'b1}}),
        .found    (w_first_found),
        .idx      (w_first_idx)
    );

    next_channel_find #(.N(CHANNEL_N), .SEL_W(SEL_W)) u_next_find (
        .en       (r_en_q),
        .from_idx ({1'b0, r_mux_sel}),
        .found    (w_next_found),
        .idx      (w_next_idx)
    );

    // Highest enabled channel of the new and the current mask, for out_last.
    always_comb begin
        w_hi_new = '0;
        w_hi_q   = '0;
        for (int i = 0; i < CHANNEL_N; i++) begin
            if (ch_en[i])  w_hi_new = SEL_W'(i);
            if (r_en_q[i]) w_hi_q   = SEL_W'(i);
        end
    end

    assign w_hs       = r_out_valid & out_ready;
    assign w_final_hs = (r_state == SEND) & w_hs & r_out_last;
    assign w_accept   = start & ((r_state == IDLE) | w_final_hs);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_ch     = r_mux_sel;
        w_ld_row    = r_out_row;
        w_ld_hi     = w_hi_q;
        if (w_accept) begin
            w_state_nxt = IDLE;
            if (w_first_found) begin
                w_state_nxt = SEND;
                w_load      = 1'b1;
                w_ld_ch     = w_first_idx;
                w_ld_row    = '0;
                w_ld_hi     = w_hi_new;
            end
        end else if ((r_state == SEND) && w_hs) begin
            if (r_out_last) begin
                w_state_nxt = IDLE;
            end else if (r_out_row != C_LAST_ROW) begin
                w_load   = 1'b1;
                w_ld_row = r_out_row + ROW_W'(1);
            end else begin
                // A non-last final row guarantees a higher enabled channel.
                w_load   = 1'b1;
                w_ld_ch  = w_next_idx;
                w_ld_row = '0;
            end
        end
    end

    assign w_ld_last = (w_ld_ch == w_ld_hi) && (w_ld_row == C_LAST_ROW);

    always_comb begin
        w_shift = '0;
        if (w_load && rst_n) w_shift[w_ld_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_en_q      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_mux_sel   <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_final_hs | (w_accept & ~w_first_found);
            r_start_err <= start & (r_state == SEND) & ~w_final_hs;
            if (w_accept) r_en_q <= ch_en;
            if (w_load) begin
                r_out_data  <= w_rows[w_ld_ch];
                r_mux_sel   <= w_ld_ch;
                r_out_row   <= w_ld_row;
                r_out_last  <= w_ld_last;
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ser_shift = w_shift;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign mux_sel   = r_mux_sel;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;
    assign busy      = (r_state == SEND);
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_channel_drain_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_drain_mux
// Description : Self-checking bench with a beat-queue model of the drain mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_drain_mux;

    localparam int CHANNEL_N = 4;
    localparam int POX       = 3;
    localparam int POY       = 3;
    localparam int DATA_W    = 16;
    localparam int BEAT_W    = POX * DATA_W;

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic [CHANNEL_N-1:0]          ch_en;
    logic [CHANNEL_N*BEAT_W-1:0]   ser_data;
    logic [CHANNEL_N-1:0]          ser_shift;
    logic [BEAT_W-1:0]             out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [1:0]                    mux_sel;
    logic [1:0]                    out_row;
    logic                          out_last;
    logic                          busy;
    logic                          done;
    logic                          start_err;

    channel_drain_mux #(
        .CHANNEL_N(CHANNEL_N), .POX(POX), .POY(POY), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_en(ch_en),
        .ser_data(ser_data), .ser_shift(ser_shift), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .mux_sel(mux_sel),
        .out_row(out_row), .out_last(out_last), .busy(busy), .done(done),
        .start_err(start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          row;
        logic [47:0] data;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic        exp_done, exp_err;
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          ptr[CHANNEL_N];
    int          lg_sel[$], lg_row[$], lg_cyc[$], done_cyc[$];
    logic [47:0] lg_data[$];
    bit          lg_last[$];
    int          sh_cnt[CHANNEL_N];
    bit          bp_mode = 0;
    int          bp_i    = 0;
    logic [3:0]  bp_pat  = 4'b1001;

    function automatic logic [47:0] row_word(input int c, input int r);
        logic [15:0] w;
        w = 16'(c * 4096 + r * 16);
        return {w, w, w};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serializer model: row pointer per channel, wraps every POY rows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNEL_N; c++) ptr[c] <= 0;
        end else begin
            for (int c = 0; c < CHANNEL_N; c++) if (ser_shift[c]) ptr[c] <= ptr[c] + 1;
        end
    end

    always_comb begin
        ser_data = '0;
        for (int c = 0; c < CHANNEL_N; c++) ser_data[c*BEAT_W +: BEAT_W] = row_word(c, ptr[c] % POY);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: queue of beats still owed downstream.
    always @(posedge clk or negedge rst_n) begin
        int  n, hi;
        bit  hs, fin, acc;
        if (!rst_n) begin
            exp_q.delete();
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
        end else begin
            n   = exp_q.size();
            hs  = (n > 0) && out_ready;
            fin = hs && (n == 1);
            acc = start && ((n == 0) || fin);
            exp_done <= fin || (acc && (ch_en == 0));
            exp_err  <= start && (n > 0) && !fin;
            if (hs) void'(exp_q.pop_front());
            if (acc) begin
                hi = -1;
                for (int c = 0; c < CHANNEL_N; c++) if (ch_en[c]) hi = c;
                for (int c = 0; c < CHANNEL_N; c++) begin
                    if (ch_en[c]) begin
                        for (int r = 0; r < POY; r++)
                            exp_q.push_back('{c, r, row_word(c, r), (c == hi) && (r == POY - 1)});
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus logging for literal pins.
    always @(negedge clk) begin
        int         n;
        bit         hs, fin, acc;
        logic [3:0] es;
        n = exp_q.size();
        check("out_valid", out_valid, n > 0);
        check("busy", busy, n > 0);
        check("done", done, exp_done);
        check("start_err", start_err, exp_err);
        es = 4'b0;
        if (rst_n) begin
            hs  = (n > 0) && out_ready;
            fin = hs && (n == 1);
            acc = start && ((n == 0) || fin);
            if (acc && (ch_en != 0)) es = ch_en & (~ch_en + 4'd1);
            else if (hs && !fin)     es = 4'b1 << exp_q[1].sel;
        end
        check("ser_shift", ser_shift, es);
        if (n > 0) begin
            check("out_data", out_data, exp_q[0].data);
            check("mux_sel", mux_sel, exp_q[0].sel);
            check("out_row", out_row, exp_q[0].row);
            check("out_last", out_last, exp_q[0].last);
        end
        for (int c = 0; c < CHANNEL_N; c++) if (ser_shift[c]) sh_cnt[c]++;
        if (rst_n && out_valid && out_ready) begin
            lg_sel.push_back(int'(mux_sel));
            lg_row.push_back(int'(out_row));
            lg_cyc.push_back(cyc);
            lg_data.push_back(out_data);
            lg_last.push_back(out_last);
        end
        if (done) done_cyc.push_back(cyc);
    end

    always begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_i % 4];
            bp_i++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] m, output int t);
        start = 1'b1;
        ch_en = m;
        t     = cyc;
        tick();
        start = 1'b0;
        ch_en = ~m;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", k < budget, 1);
        tick();
        tick();
    endtask

    initial begin
        int t, t2, b, db, k;
        int s0, s1, s2;
        rst_n = 1'b0; start = 1'b0; ch_en = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sel_row_last", {mux_sel, out_row, out_last}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // All channels enabled
        b = lg_cyc.size(); db = done_cyc.size();
        pulse_start(4'b1111, t);
        wait_idle(40);
        check("all_count", lg_cyc.size() - b, 12);
        check("all_first_cyc", lg_cyc[b], t + 1);
        check("all_last_cyc", lg_cyc[b+11], t + 12);
        check("all_beat5_data", lg_data[b+4], {3{16'h1010}});
        check("all_beat12_data", lg_data[b+11], {3{16'h3020}});
        check("all_last_flags", {lg_last[b+10], lg_last[b+11]}, 2'b01);
        check("all_done_cyc", done_cyc[db], t + 13);

        // Mask skip
        b = lg_cyc.size(); s0 = sh_cnt[0]; s1 = sh_cnt[1]; s2 = sh_cnt[2];
        pulse_start(4'b1010, t);
        wait_idle(40);
        check("skip_count", lg_cyc.size() - b, 6);
        check("skip_first_sel", lg_sel[b], 1);
        check("skip_fourth_sel", lg_sel[b+3], 3);
        check("skip_no_gap", lg_cyc[b+3], t + 4);
        check("skip_shift0", sh_cnt[0] - s0, 0);
        check("skip_shift2", sh_cnt[2] - s2, 0);
        check("skip_shift1", sh_cnt[1] - s1, 3);

        // Backpressure
        b = lg_cyc.size();
        bp_i = 0; bp_mode = 1;
        pulse_start(4'b1001, t);
        wait_idle(80);
        bp_mode = 0; out_ready = 1'b1;
        check("bp_count", lg_cyc.size() - b, 6);
        for (int i = 0; i < 6; i++) begin
            check("bp_sel", lg_sel[b+i], (i < 3) ? 0 : 3);
            check("bp_row", lg_row[b+i], i % 3);
        end

        // Empty mask
        pulse_start(4'b0000, t);
        @(negedge clk);
        check("empty_done", done, 1);
        check("empty_valid", out_valid, 0);
        check("empty_busy", busy, 0);
        tick(); tick();

        // Start while busy
        b = lg_cyc.size();
        pulse_start(4'b1111, t);
        tick(); tick(); tick();
        pulse_start(4'b0001, t2);
        @(negedge clk);
        check("busy_start_err", start_err, 1);
        wait_idle(40);
        check("busy_count", lg_cyc.size() - b, 12);

        // Back-to-back start on the final handshake
        b = lg_cyc.size(); db = done_cyc.size();
        pulse_start(4'b1111, t);
        k = 0;
        while (cyc < t + 12 && k < 40) begin tick(); k++; end
        pulse_start(4'b0100, t2);
        wait_idle(40);
        check("b2b_count", lg_cyc.size() - b, 15);
        check("b2b_next_cyc", lg_cyc[b+12], t + 13);
        check("b2b_next_sel_row", {lg_sel[b+12], lg_row[b+12]}, {32'd2, 32'd0});
        check("b2b_done_cyc", done_cyc[db], t + 13);
        check("b2b_done_count", done_cyc.size() - db, 2);

        // Reset mid-transfer
        b = lg_cyc.size();
        pulse_start(4'b1111, t);
        k = 0;
        while (lg_cyc.size() < b + 5 && k < 40) begin tick(); k++; end
        check("rstmid_reach", lg_cyc.size() >= b + 5, 1);
        db = done_cyc.size();
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_data", out_data, 0);
        check("rstmid_shift", ser_shift, 0);
        check("rstmid_sel_row_last", {mux_sel, out_row, out_last}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        check("rstmid_no_done", done_cyc.size() - db, 0);
        b = lg_cyc.size();
        pulse_start(4'b0110, t);
        wait_idle(40);
        check("rstmid_after_count", lg_cyc.size() - b, 6);
        check("rstmid_after_data", lg_data[b], {3{16'h1000}});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
